// File: rtl/writeback_queue_if.sv
// Handshake bundle between execution results, the writeback queue and the VRF write port.
// slave = queue side, master = producer/VRF side.
interface writeback_queue_if #(
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = 64
);
  logic                  result_valid;
  logic [TAG_WIDTH-1:0]  result_tag;
  logic [DATA_WIDTH-1:0] result_data;
  logic                  result_ready;
  logic                  vrf_write_enable;
  logic [TAG_WIDTH-1:0]  vrf_write_tag;
  logic [DATA_WIDTH-1:0] vrf_write_data;
  logic                  vrf_write_ready;

  modport slave (
    input  result_valid, result_tag, result_data,
    input  vrf_write_ready,
    output result_ready,
    output vrf_write_enable, vrf_write_tag, vrf_write_data
  );

  modport master (
    output result_valid, result_tag, result_data,
    output vrf_write_ready,
    input  result_ready,
    input  vrf_write_enable, vrf_write_tag, vrf_write_data
  );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback FIFO from execute to the VRF write port, head shown ahead.
// Optional WRITEBACK_COALESCE_EN merges a push into a queued entry with the same tag.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int NUMBER_PHYSICAL_REGISTERS = 64,
  parameter int TAG_WIDTH = $clog2(NUMBER_PHYSICAL_REGISTERS),
  parameter int DATA_WIDTH = 64,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  writeback_queue_if.slave bus,
  output logic [CW-1:0] occupancy,
  output logic          overflow_error
);

  typedef enum logic [1:0] {
    EMPTY,
    ACTIVE,
    FULL
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic [DEPTH-1:0] valid_q;

  logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic ready;
  logic head_valid;
  logic pop;
  logic alloc;
  logic hit;
  logic merge;
  logic [PW-1:0] hit_idx;

  assign ready      = (state_q != FULL);
  assign head_valid = (state_q != EMPTY);
  assign pop        = head_valid && bus.vrf_write_ready && !flush;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
`ifdef WRITEBACK_COALESCE_EN
    // the popping head is leaving, so it cannot absorb the new value
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && tag_q[i] == bus.result_tag &&
          !(pop && PW'(i) == rd_ptr)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
`else
    hit     = 1'b0;
    hit_idx = '0;
`endif
  end

  assign merge = bus.result_valid && hit && !flush;
  assign alloc = bus.result_valid && ready && !hit && !flush;

  assign bus.result_ready     = ready;
  assign bus.vrf_write_enable = head_valid;
  assign bus.vrf_write_tag    = head_valid ? tag_q[rd_ptr]  : '0;
  assign bus.vrf_write_data   = head_valid ? data_q[rd_ptr] : '0;

  assign occupancy      = count_q;
  assign overflow_error = ovf_q;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY:  if (alloc) state_d = ACTIVE;
        ACTIVE: begin
          if (alloc && !pop && count_q == CW'(DEPTH - 1))
            state_d = FULL;
          else if (pop && !alloc && count_q == CW'(1))
            state_d = EMPTY;
        end
        FULL:   if (pop) state_d = ACTIVE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (bus.result_valid && !ready && !hit && !flush)
        ovf_q <= 1'b1;
      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
        valid_q <= '0;
      end else begin
        if (alloc) begin
          valid_q[wr_ptr] <= 1'b1;
          wr_ptr          <= wr_ptr + 1'b1;
        end
        if (pop) begin
          valid_q[rd_ptr] <= 1'b0;
          rd_ptr          <= rd_ptr + 1'b1;
        end
        count_q <= count_q + CW'(alloc) - CW'(pop);
      end
    end
  end

  // payload storage carries no reset; valid_q alone defines content
  always_ff @(posedge clock) begin
    if (merge) begin
      data_q[hit_idx] <= bus.result_data;
    end else if (alloc) begin
      tag_q[wr_ptr]  <= bus.result_tag;
      data_q[wr_ptr] <= bus.result_data;
    end
  end

endmodule
